// File: rtl/bp_fe_cache_req_arbiter_pkg.sv
// Shared types and helpers for the FE cache request arbiter.
package bp_fe_pkg;

   typedef enum logic {
      e_idle = 1'b0,
      e_wait = 1'b1
   } bp_fe_cache_req_arb_state_e;

   // Width of a counter/index covering x values, never less than one bit.
   function automatic int unsigned safe_clog2(input int unsigned x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bp_fe_cache_req_arbiter_arb.sv
// Round-robin arbiter: priority starts at the pointer, pointer moves past the winner on yumi.
module bsg_arb_round_robin
   import bp_fe_pkg::*;
#(
   parameter int unsigned width_p = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              grants_en_i,
   input  logic [width_p-1:0]                reqs_i,
   output logic [width_p-1:0]                grants_o,
   output logic                              v_o,
   output logic [safe_clog2(width_p)-1:0]    tag_o,
   input  logic                              yumi_i
);

   localparam int unsigned ptr_w = safe_clog2(width_p);
   localparam logic [ptr_w-1:0] last_idx = ptr_w'(width_p - 1);

   logic [ptr_w-1:0]   ptr_r;
   logic [width_p-1:0] sel_one_hot;
   int unsigned        best_d;
   int unsigned        d;
   int unsigned        ptr_ext;

   // Winner is the requester with the smallest forward distance from the pointer.
   always_comb begin
      best_d  = width_p;
      d       = 0;
      ptr_ext = 32'(ptr_r);
      v_o     = 1'b0;
      tag_o   = '0;
      for (int unsigned j = 0; j < width_p; j++) begin
         if (reqs_i[j]) begin
            d = (j >= ptr_ext) ? (j - ptr_ext) : (j + width_p - ptr_ext);
            if (d < best_d) begin
               best_d = d;
               tag_o  = ptr_w'(j);
               v_o    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      sel_one_hot = '0;
      for (int unsigned j = 0; j < width_p; j++) begin
         sel_one_hot[j] = v_o && (ptr_w'(j) == tag_o);
      end
   end

   assign grants_o = grants_en_i ? sel_one_hot : '0;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_r <= '0;
      end else if (yumi_i) begin
         ptr_r <= (tag_o == last_idx) ? '0 : tag_o + 1'b1;
      end
   end

endmodule

// File: rtl/bp_fe_cache_req_arbiter.sv
// Shares the FE-to-LCE cache request port among requesters, one outstanding
// transaction at a time, with a watchdog and sticky protocol error flag.
module bp_fe_cache_req_arbiter
   import bp_fe_pkg::*;
#(
   parameter int unsigned num_req_p         = 2,
   parameter int unsigned cache_req_width_p = 96,
   parameter int unsigned metadata_width_p  = 8,
   parameter int unsigned timeout_p         = 4096
) (
   input  logic                                    clk_i,
   input  logic                                    reset_i,
   input  logic [num_req_p*cache_req_width_p-1:0]  req_i,
   input  logic [num_req_p-1:0]                    req_v_i,
   output logic [num_req_p-1:0]                    req_yumi_o,
   input  logic [num_req_p*metadata_width_p-1:0]   req_metadata_i,
   input  logic [num_req_p-1:0]                    req_metadata_v_i,
   output logic [num_req_p-1:0]                    req_complete_o,
   output logic [cache_req_width_p-1:0]            cache_req_o,
   output logic                                    cache_req_v_o,
   input  logic                                    cache_req_ready_i,
   output logic [metadata_width_p-1:0]             cache_req_metadata_o,
   output logic                                    cache_req_metadata_v_o,
   input  logic                                    cache_req_complete_i,
   output logic                                    busy_o,
   output logic                                    timeout_o,
   output logic                                    protocol_err_o
);

   localparam int unsigned ptr_w = safe_clog2(num_req_p);
   localparam int unsigned wd_w  = safe_clog2(timeout_p + 1);

   bp_fe_cache_req_arb_state_e state_r, state_n;

   logic [ptr_w-1:0]             grant_r;
   logic [wd_w-1:0]              wd_r;
   logic                         timeout_r;
   logic                         err_r;
   logic [ptr_w-1:0]             sel;
   logic                         arb_v;
   logic [num_req_p-1:0]         arb_grants;
   logic                         is_idle;
   logic                         handshake;
   logic [cache_req_width_p-1:0] req_arr [num_req_p];
   logic [metadata_width_p-1:0]  md_arr  [num_req_p];

   always_comb begin
      for (int unsigned r = 0; r < num_req_p; r++) begin
         req_arr[r] = req_i[r*cache_req_width_p +: cache_req_width_p];
         md_arr[r]  = req_metadata_i[r*metadata_width_p +: metadata_width_p];
      end
   end

   assign is_idle   = (state_r == e_idle);
   assign handshake = is_idle & arb_v & cache_req_ready_i & ~reset_i;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) arb (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .grants_en_i (is_idle & cache_req_ready_i),
      .reqs_i      (req_v_i),
      .grants_o    (arb_grants),
      .v_o         (arb_v),
      .tag_o       (sel),
      .yumi_i      (handshake)
   );

   // Idle-state outputs are pure pass-through, so reset masks them explicitly.
   always_comb begin
      state_n                = state_r;
      cache_req_v_o          = 1'b0;
      cache_req_o            = '0;
      req_yumi_o             = '0;
      cache_req_metadata_o   = '0;
      cache_req_metadata_v_o = 1'b0;
      req_complete_o         = '0;
      busy_o                 = 1'b0;
      case (state_r)
         e_idle: begin
            if (!reset_i) begin
               cache_req_v_o = arb_v;
               cache_req_o   = req_arr[sel];
               req_yumi_o    = arb_grants;
               if (handshake) begin
                  state_n = e_wait;
               end
            end
         end
         e_wait: begin
            busy_o                 = 1'b1;
            cache_req_metadata_o   = md_arr[grant_r];
            cache_req_metadata_v_o = req_metadata_v_i[grant_r];
            if (cache_req_complete_i) begin
               req_complete_o[grant_r] = 1'b1;
               state_n                 = e_idle;
            end
         end
         default: state_n = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r   <= e_idle;
         grant_r   <= '0;
         wd_r      <= '0;
         timeout_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r <= state_n;
         if (handshake) begin
            grant_r <= sel;
            wd_r    <= '0;
         end else if (!is_idle && (wd_r != wd_w'(timeout_p))) begin
            wd_r <= wd_r + 1'b1;
         end
         if (!is_idle && !cache_req_complete_i && (wd_r == wd_w'(timeout_p - 1))) begin
            timeout_r <= 1'b1;
         end
         if (is_idle && (cache_req_complete_i || (|req_metadata_v_i))) begin
            err_r <= 1'b1;
         end
      end
   end

   assign timeout_o      = timeout_r;
   assign protocol_err_o = err_r;

endmodule

// File: tb/tb_bp_fe_cache_req_arbiter.sv
// Directed bench for bp_fe_cache_req_arbiter: per-cycle vector table plus hand-written sequences.
module tb_bp_fe_cache_req_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned RW = 96;
   localparam int unsigned MW = 8;
   localparam int unsigned TO = 16;

   localparam logic [RW-1:0] REQ0 = 96'hA000_0000_1111_2222_3333_4444;
   localparam logic [RW-1:0] REQ1 = 96'hB100_0000_5555_6666_7777_8888;
   localparam logic [MW-1:0] MD0  = 8'h5A;
   localparam logic [MW-1:0] MD1  = 8'hC3;

   logic            clk;
   logic            reset;
   logic [N*RW-1:0] req;
   logic [N-1:0]    req_v;
   logic [N-1:0]    req_yumi;
   logic [N*MW-1:0] req_md;
   logic [N-1:0]    req_md_v;
   logic [N-1:0]    req_complete;
   logic [RW-1:0]   cache_req;
   logic            cache_req_v;
   logic            cache_req_ready;
   logic [MW-1:0]   cache_md;
   logic            cache_md_v;
   logic            cache_complete;
   logic            busy;
   logic            timeout;
   logic            protocol_err;

   bp_fe_cache_req_arbiter #(
      .num_req_p         (N),
      .cache_req_width_p (RW),
      .metadata_width_p  (MW),
      .timeout_p         (TO)
   ) dut (
      .clk_i                  (clk),
      .reset_i                (reset),
      .req_i                  (req),
      .req_v_i                (req_v),
      .req_yumi_o             (req_yumi),
      .req_metadata_i         (req_md),
      .req_metadata_v_i       (req_md_v),
      .req_complete_o         (req_complete),
      .cache_req_o            (cache_req),
      .cache_req_v_o          (cache_req_v),
      .cache_req_ready_i      (cache_req_ready),
      .cache_req_metadata_o   (cache_md),
      .cache_req_metadata_v_o (cache_md_v),
      .cache_req_complete_i   (cache_complete),
      .busy_o                 (busy),
      .timeout_o              (timeout),
      .protocol_err_o         (protocol_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [1:0] v;
      logic       rdy;
      logic       cpl;
      logic [1:0] mdv;
      logic [1:0] yumi;
      logic       vo;
      logic       sel;
      logic [1:0] cpo;
      logic       busy;
      logic       mdvo;
      logic       err;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] v, input logic rdy, input logic cpl, input logic [1:0] mdv);
      @(negedge clk);
      req_v           = v;
      cache_req_ready = rdy;
      cache_complete  = cpl;
      req_md_v        = mdv;
      #1;
   endtask

   function automatic vec_t mk(input logic [1:0] v, input logic rdy, input logic cpl, input logic [1:0] mdv,
                               input logic [1:0] yumi, input logic vo, input logic sel, input logic [1:0] cpo,
                               input logic bsy, input logic mdvo, input logic err);
      vec_t t;
      t.v = v; t.rdy = rdy; t.cpl = cpl; t.mdv = mdv;
      t.yumi = yumi; t.vo = vo; t.sel = sel; t.cpo = cpo;
      t.busy = bsy; t.mdvo = mdvo; t.err = err;
      return t;
   endfunction

   initial begin
      reset           = 1'b1;
      req             = {REQ1, REQ0};
      req_md          = {MD1, MD0};
      req_v           = '0;
      req_md_v        = '0;
      cache_req_ready = 1'b0;
      cache_complete  = 1'b0;

      //                v     rdy   cpl   mdv     yumi  vo    sel   cpo    busy  mdvo  err
      vecs.push_back(mk(2'b01,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b0,2'b01, 2'b00,1'b0,1'b0,2'b00, 1'b1,1'b1,1'b0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(2'b00,1'b0,1'b0,2'b00, 2'b00,1'b0,1'b0,2'b00, 1'b1,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b1,2'b00, 2'b00,1'b0,1'b0,2'b01, 1'b1,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b0,2'b00, 2'b00,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0));
      // contention: pointer now sits at requester 1
      vecs.push_back(mk(2'b11,1'b1,1'b0,2'b00, 2'b10,1'b1,1'b1,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b11,1'b1,1'b1,2'b00, 2'b00,1'b0,1'b1,2'b10, 1'b1,1'b0,1'b0));
      vecs.push_back(mk(2'b11,1'b1,1'b0,2'b00, 2'b01,1'b1,1'b0,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b11,1'b0,1'b1,2'b01, 2'b00,1'b0,1'b0,2'b01, 1'b1,1'b1,1'b0));
      vecs.push_back(mk(2'b11,1'b1,1'b0,2'b00, 2'b10,1'b1,1'b1,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b0,2'b01, 2'b00,1'b0,1'b1,2'b00, 1'b1,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b0,2'b10, 2'b00,1'b0,1'b1,2'b00, 1'b1,1'b1,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b1,2'b00, 2'b00,1'b0,1'b1,2'b10, 1'b1,1'b0,1'b0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(2'b10,1'b0,1'b0,2'b00, 2'b00,1'b1,1'b1,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b10,1'b1,1'b0,2'b00, 2'b10,1'b1,1'b1,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b1,2'b00, 2'b00,1'b0,1'b1,2'b10, 1'b1,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b1,2'b00, 2'b00,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b0));
      vecs.push_back(mk(2'b00,1'b0,1'b0,2'b00, 2'b00,1'b0,1'b0,2'b00, 1'b0,1'b0,1'b1));
      vecs.push_back(mk(2'b01,1'b0,1'b0,2'b00, 2'b00,1'b1,1'b0,2'b00, 1'b0,1'b0,1'b1));

      @(negedge clk);
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_timeout", timeout, 1'b0);
      check("reset_err", protocol_err, 1'b0);
      check("reset_v", cache_req_v, 1'b0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].v, vecs[i].rdy, vecs[i].cpl, vecs[i].mdv);
         check($sformatf("vec%0d_yumi", i), req_yumi, vecs[i].yumi);
         check($sformatf("vec%0d_v", i), cache_req_v, vecs[i].vo);
         check($sformatf("vec%0d_complete", i), req_complete, vecs[i].cpo);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
         check($sformatf("vec%0d_md_v", i), cache_md_v, vecs[i].mdvo);
         check($sformatf("vec%0d_err", i), protocol_err, vecs[i].err);
         check($sformatf("vec%0d_timeout", i), timeout, 1'b0);
         if (vecs[i].vo)
            check($sformatf("vec%0d_req", i), cache_req, vecs[i].sel ? REQ1 : REQ0);
         if (vecs[i].mdvo)
            check($sformatf("vec%0d_md", i), cache_md, vecs[i].sel ? MD1 : MD0);
      end

      // watchdog: clear sticky flags, then leave one transaction open
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #3 reset = 1'b0;
      step(2'b01, 1'b1, 1'b0, 2'b00);
      check("wd_yumi", req_yumi, 2'b01);
      check("wd_err_cleared", protocol_err, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         step(2'b00, 1'b0, 1'b0, 2'b00);
         check($sformatf("wd_busy_%0d", k), busy, 1'b1);
         check($sformatf("wd_timeout_pre_%0d", k), timeout, 1'b0);
      end
      step(2'b00, 1'b0, 1'b0, 2'b00);
      check("wd_timeout_set", timeout, 1'b1);
      check("wd_busy_after", busy, 1'b1);
      step(2'b00, 1'b0, 1'b1, 2'b00);
      check("wd_late_complete", req_complete, 2'b01);
      step(2'b00, 1'b0, 1'b0, 2'b00);
      check("wd_idle_busy", busy, 1'b0);
      check("wd_timeout_sticky", timeout, 1'b1);

      // async reset in the middle of a wait
      step(2'b11, 1'b1, 1'b0, 2'b00);
      check("ar_yumi", req_yumi, 2'b10);
      step(2'b11, 1'b1, 1'b0, 2'b01);
      check("ar_busy", busy, 1'b1);
      check("ar_stray_md", cache_md_v, 1'b0);
      cache_complete = 1'b1;
      #2 reset = 1'b1;
      #1;
      check("ar_busy0", busy, 1'b0);
      check("ar_v0", cache_req_v, 1'b0);
      check("ar_yumi0", req_yumi, 2'b00);
      check("ar_req0", cache_req, '0);
      check("ar_md_v0", cache_md_v, 1'b0);
      check("ar_complete0", req_complete, 2'b00);
      check("ar_timeout0", timeout, 1'b0);
      check("ar_err0", protocol_err, 1'b0);
      @(negedge clk);
      req_v           = 2'b00;
      cache_req_ready = 1'b0;
      cache_complete  = 1'b0;
      req_md_v        = 2'b00;
      #3 reset = 1'b0;
      step(2'b11, 1'b1, 1'b0, 2'b00);
      check("post_reset_yumi", req_yumi, 2'b01);
      check("post_reset_req", cache_req, REQ0);
      step(2'b11, 1'b0, 1'b1, 2'b00);
      check("post_reset_complete", req_complete, 2'b01);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
